// File: rtl/board_store.sv
// Board register for the 4x8 dark-chess game.
// Holds 32 five-bit squares {color, type[2:0], state}, accepts single-square
// writes from the game logic while idle, and on request deals a covered,
// Fisher-Yates shuffled layout using a free-running 16-bit LFSR.
module board_store #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic         CLK,
   input  logic         RESET_N,
   input  logic         shuffle_start,
   input  logic         wr_en,
   input  logic [4:0]   wr_addr,
   input  logic [4:0]   wr_piece,
   output logic [159:0] board_output,
   output logic         busy,
   output logic         shuffle_done,
   output logic [4:0]   red_count,
   output logic [4:0]   black_count
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHUFFLE,
      ST_DONE
   } state_t;

   state_t      r_state;
   logic [4:0]  r_board [32];
   logic [4:0]  r_idx;
   logic [15:0] r_lfsr;
   logic        r_busy;
   logic        r_done;

   logic [4:0]  w_mask;
   logic [4:0]  w_j;
   logic        w_accept;
   logic        w_fb;
   logic [5:0]  w_red_acc;
   logic [5:0]  w_black_acc;

   // Canonical square k: red for k<16, black above; type from k mod 16; covered.
   function automatic logic [4:0] canon_piece(input logic [4:0] k);
      logic [2:0] t;
      case (k[3:0])
         4'd0:          t = 3'b111;
         4'd1, 4'd2:    t = 3'b110;
         4'd3, 4'd4:    t = 3'b101;
         4'd5, 4'd6:    t = 3'b100;
         4'd7, 4'd8:    t = 3'b011;
         4'd9, 4'd10:   t = 3'b010;
         default:       t = 3'b001;
      endcase
      return {k[4], t, 1'b0};
   endfunction

   // Candidate index: smallest all-ones mask covering i, so j<=i is likely.
   always_comb begin
      w_mask = 5'd1;
      if (r_idx >= 5'd16)      w_mask = 5'd31;
      else if (r_idx >= 5'd8)  w_mask = 5'd15;
      else if (r_idx >= 5'd4)  w_mask = 5'd7;
      else if (r_idx >= 5'd2)  w_mask = 5'd3;
      w_j      = r_lfsr[4:0] & w_mask;
      w_accept = (w_j <= r_idx);
      w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   end

   // Fibonacci LFSR (taps 16,14,13,11) runs every cycle so the deal depends on key timing.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_lfsr <= SEED_EFF;
      else          r_lfsr <= {r_lfsr[14:0], w_fb};
   end

   // Deal sequencer: IDLE -> LOAD -> SHUFFLE (i=31..1) -> DONE, with registered busy/done.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= ST_IDLE;
         r_idx   <= 5'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (shuffle_start) begin
                  r_state <= ST_LOAD;
                  r_busy  <= 1'b1;
               end
            end
            ST_LOAD: begin
               r_idx   <= 5'd31;
               r_state <= ST_SHUFFLE;
            end
            ST_SHUFFLE: begin
               if (w_accept) begin
                  if (r_idx == 5'd1) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx <= r_idx - 5'd1;
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Board storage: idle writes (shuffle request wins), canonical load, and one swap per accepted candidate.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int k = 0; k < 32; k++) r_board[k[4:0]] <= 5'b0_000_0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (wr_en && !shuffle_start) r_board[wr_addr] <= wr_piece;
            end
            ST_LOAD: begin
               for (int k = 0; k < 32; k++) r_board[k[4:0]] <= canon_piece(k[4:0]);
            end
            ST_SHUFFLE: begin
               if (w_accept) begin
                  r_board[r_idx] <= r_board[w_j];
                  r_board[w_j]   <= r_board[r_idx];
               end
            end
            default: ;
         endcase
      end
   end

   // Flatten the board: square k occupies bits [5k+4:5k].
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_flat
         assign board_output[5*gi +: 5] = r_board[gi];
      end
   endgenerate

   // Live piece counts per colour from the registered board.
   always_comb begin
      w_red_acc   = 6'd0;
      w_black_acc = 6'd0;
      for (int k = 0; k < 32; k++) begin
         if (r_board[k[4:0]][3:1] != 3'b000) begin
            if (r_board[k[4:0]][4]) w_black_acc = w_black_acc + 6'd1;
            else                    w_red_acc   = w_red_acc + 6'd1;
         end
      end
   end

   assign red_count    = w_red_acc[4:0];
   assign black_count  = w_black_acc[4:0];
   assign busy         = r_busy;
   assign shuffle_done = r_done;

endmodule

// File: doc/board_store.md
Name: board_store

Overview:
- Board register for the 4x8 dark-chess game.
- Holds 32 five-bit squares and presents them flattened to the game logic stage.
- Accepts that stage's single-square write commands.
- On request, deals a fresh covered, randomly shuffled 32-piece layout. Shuffling is a Fisher-Yates pass driven by a free-running LFSR.
- Also reports live piece counts per colour for win detection by the display/status logic.

Parameters:
- LFSR_SEED, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- shuffle_start  input  1  single-cycle pulse; request a new dealt board.
- wr_en  input  1  write strobe from game logic.
- wr_addr  input  5  square index {row[1:0], col[2:0]}.
- wr_piece  input  5  piece code {color, type[2:0], state}.
- board_output  output  160  square k at bits [5k+4:5k], all 32 squares valid.
- busy  output  1  high while dealing/shuffling.
- shuffle_done  output  1  single-cycle pulse when the new board is complete.
- red_count  output  5  squares with type!=000 and color=0, range 0..16.
- black_count  output  5  squares with type!=000 and color=1, range 0..16.

Behaviour:
- Reset (async, RESET_N low):
  - All 32 squares become 5'b0_000_0.
  - FSM goes to IDLE; busy=0, shuffle_done=0.
  - LFSR is loaded with the seed.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle outside reset, in every state, so the deal depends on the timing of the key press.
- Writes:
  - In IDLE with wr_en=1, board[wr_addr] takes wr_piece at the clock edge and is visible on board_output the next cycle.
  - Back-to-back writes on consecutive cycles are supported.
  - Writes outside IDLE are dropped silently.
- Counts are combinational from the registered board, so they update in the same cycle board_output changes.
- FSM states: IDLE, LOAD, SHUFFLE, DONE.
- IDLE -> LOAD:
  - Occurs on shuffle_start.
  - If shuffle_start and wr_en arrive in the same cycle, shuffle wins and the write is dropped.
  - busy=1 from the next cycle.
- LOAD (1 cycle): writes the canonical layout.
  - Squares 0..15 are red (color 0); squares 16..31 are black (color 1).
  - Type by k mod 16: 0 KING(111); 1-2 QUEEN(110); 3-4 BISHOP(101); 5-6 ROOK(100); 7-8 KNIGHT(011); 9-10 CANNON(010); 11-15 SOLDIER(001).
  - State bit is 0 (covered) on every square.
  - Sets index i=31.
- SHUFFLE (one candidate per cycle):
  - mask(i): 31 if i>=16; 15 if i>=8; 7 if i>=4; 3 if i>=2; 1 if i==1.
  - j = lfsr[4:0] & mask(i).
  - If j<=i: swap board[i] and board[j] in one edge (j==i leaves the square unchanged), then decrement i.
  - If j>i: reject the candidate, leave the board and i unchanged, and retry next cycle.
  - After the swap at i==1, go to DONE.
- DONE (1 cycle):
  - shuffle_done=1; busy stays 1 in this cycle.
  - Next cycle: IDLE, busy=0, shuffle_done=0.
- shuffle_start while busy is ignored.
- Board contents during LOAD/SHUFFLE are intermediate; consumers must wait for shuffle_done.
- Reset mid-shuffle aborts immediately to the reset state with no shuffle_done pulse.
- Invariants after DONE:
  - The multiset of the 32 codes equals the canonical layout.
  - red_count = black_count = 16.
  - Every state bit is 0.
- Latency:
  - Minimum 1 (LOAD) + 31 (SHUFFLE) + 1 (DONE) = 33 cycles from shuffle_start to shuffle_done.
  - Benches assert completion within 200 cycles.

Test Plan:
- Reset:
  - Drive RESET_N low, then release.
  - Required: board_output=160'h0, busy=0, shuffle_done=0, red_count=0, black_count=0.
- Deal:
  - Pulse shuffle_start.
  - Required: busy=1 next cycle; shuffle_done pulses exactly once between 33 and 200 cycles later; afterwards busy=0.
  - Required counts: red_count=16, black_count=16.
  - Required per colour: exactly one 111, two each of 110/101/100/011/010, five 001.
  - Required: all state bits 0.
- Randomness: two deals started 1 and 7 cycles after reset (same seed) produce differing board_output.
- Write:
  - After a deal, write wr_addr=5'b01_010, wr_piece=5'b1_011_1.
  - Required next cycle: board_output[54:50]=5'b10111.
  - Then write 5'b0_000_0 to a square holding a red piece; red_count drops by 1 the cycle after.
- Collisions:
  - shuffle_start and wr_en in the same cycle: the write is dropped.
  - wr_en during busy: no effect after shuffle_done.
  - Second shuffle_start during busy: only one shuffle_done.
- Reset mid-shuffle:
  - Assert RESET_N low 10 cycles after shuffle_start.
  - Required: board_output=0 and busy=0 immediately (asynchronous), with no shuffle_done pulse.
